// File: rtl/oscope_pkg.sv
// Shared types and default widths for the oscilloscope capture path.
package oscope_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_ARMED,
    ST_POST,
    ST_DONE
  } cap_state_t;

  localparam int unsigned DEF_SAMPLE_W   = 12;
  localparam int unsigned DEF_DEPTH_LOG2 = 10;
  localparam int unsigned DEF_TIMEOUT_W  = 24;

  function automatic logic is_capturing(cap_state_t s);
    return (s == ST_PRE) || (s == ST_ARMED) || (s == ST_POST);
  endfunction

endpackage

// File: rtl/oscope_trig_detect.sv
// Edge/level trigger detector: remembers the previous captured sample and
// flags a threshold crossing in the selected direction.
module oscope_trig_detect
  import oscope_pkg::*;
#(
  parameter int unsigned SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                track,
  input  logic                en,
  input  logic                rising,
  input  logic [SAMPLE_W-1:0] level,
  input  logic                smp_valid,
  input  logic [SAMPLE_W-1:0] smp_data,
  output logic                trig_hit
);

  logic [SAMPLE_W-1:0] prev;
  logic                prev_valid;
  logic                rise_ok;
  logic                fall_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (clear) begin
      prev_valid <= 1'b0;
    end else if (track && smp_valid) begin
      prev       <= smp_data;
      prev_valid <= 1'b1;
    end
  end

  // A crossing needs a real previous sample from this capture on the other side.
  assign rise_ok  = (prev < level) && (smp_data >= level);
  assign fall_ok  = (prev > level) && (smp_data <= level);
  assign trig_hit = en && smp_valid && prev_valid && (rising ? rise_ok : fall_ok);

endmodule

// File: rtl/oscope_capture_ctrl.sv
// Capture sequencer: circular pre-trigger fill, trigger detect, post-trigger fill.
// Optional auto-trigger timeout is enabled by defining OSCOPE_AUTO_TRIG_EN.
module oscope_capture_ctrl
  import oscope_pkg::*;
#(
  parameter int unsigned SAMPLE_W   = DEF_SAMPLE_W,
  parameter int unsigned DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int unsigned TIMEOUT_W  = DEF_TIMEOUT_W
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [SAMPLE_W-1:0]   cfg_level,
  input  logic                  cfg_rising,
  input  logic [DEPTH_LOG2-1:0] cfg_pretrig,
  input  logic [TIMEOUT_W-1:0]  cfg_timeout,
  input  logic                  smp_valid,
  input  logic [SAMPLE_W-1:0]   smp_data,
  output logic                  buf_we,
  output logic [DEPTH_LOG2-1:0] buf_addr,
  output logic [SAMPLE_W-1:0]   buf_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DEPTH_LOG2-1:0] trig_addr,
  output logic                  forced
);

  cap_state_t            state, state_nx;
  logic [DEPTH_LOG2-1:0] ptr, pre_cnt, post_cnt, lat_pretrig;
  logic [SAMPLE_W-1:0]   lat_level;
  logic                  lat_rising;
  logic                  start, capturing, wr;
  logic                  real_hit, force_hit, hit;

  assign start     = arm && !abort && ((state == ST_IDLE) || (state == ST_DONE));
  assign capturing = is_capturing(state);
  assign wr        = capturing && smp_valid && !abort;
  assign hit       = real_hit || force_hit;

  oscope_trig_detect #(.SAMPLE_W(SAMPLE_W)) u_trig (
    .clk       (ACLK),
    .reset     (ARESET),
    .clear     (start),
    .track     (capturing),
    .en        (state == ST_ARMED),
    .rising    (lat_rising),
    .level     (lat_level),
    .smp_valid (smp_valid),
    .smp_data  (smp_data),
    .trig_hit  (real_hit)
  );

`ifdef OSCOPE_AUTO_TRIG_EN
  logic [TIMEOUT_W-1:0] lat_timeout, to_cnt;

  // Counter saturates at the timeout; any later valid sample becomes a forced trigger.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      lat_timeout <= '0;
      to_cnt      <= '0;
    end else begin
      if (start) lat_timeout <= cfg_timeout;
      if (state != ST_ARMED) to_cnt <= '0;
      else if (to_cnt != lat_timeout) to_cnt <= to_cnt + TIMEOUT_W'(1);
    end
  end

  assign force_hit = (state == ST_ARMED) && smp_valid && (lat_timeout != '0) &&
                     (to_cnt == lat_timeout);
`else
  logic unused_timeout;
  assign unused_timeout = ^cfg_timeout;
  assign force_hit      = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    if (abort) begin
      state_nx = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE:
          if (arm) state_nx = (cfg_pretrig == '0) ? ST_ARMED : ST_PRE;
        ST_PRE:
          if (smp_valid && (pre_cnt + DEPTH_LOG2'(1) == lat_pretrig)) state_nx = ST_ARMED;
        ST_ARMED:
          if (hit) state_nx = (~lat_pretrig == '0) ? ST_DONE : ST_POST;
        ST_POST:
          if (smp_valid && (post_cnt == DEPTH_LOG2'(1))) state_nx = ST_DONE;
        default:
          state_nx = ST_IDLE;
      endcase
    end
  end

  // N - pretrig - 1 modulo N is simply the bitwise inverse of pretrig.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      pre_cnt     <= '0;
      post_cnt    <= '0;
      lat_pretrig <= '0;
      lat_level   <= '0;
      lat_rising  <= 1'b0;
      buf_we      <= 1'b0;
      buf_addr    <= '0;
      buf_wdata   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      trig_addr   <= '0;
      forced      <= 1'b0;
    end else begin
      state  <= state_nx;
      buf_we <= wr;
      if (wr) begin
        buf_addr  <= ptr;
        buf_wdata <= smp_data;
        ptr       <= ptr + DEPTH_LOG2'(1);
      end
      if (start) begin
        lat_pretrig <= cfg_pretrig;
        lat_level   <= cfg_level;
        lat_rising  <= cfg_rising;
        ptr         <= '0;
        pre_cnt     <= '0;
        forced      <= 1'b0;
      end
      if ((state == ST_PRE) && wr) pre_cnt <= pre_cnt + DEPTH_LOG2'(1);
      if ((state == ST_ARMED) && hit && wr) begin
        trig_addr <= ptr;
        post_cnt  <= ~lat_pretrig;
        forced    <= !real_hit;
      end
      if ((state == ST_POST) && wr) post_cnt <= post_cnt - DEPTH_LOG2'(1);
      // done and the busy fall lag the DONE state by one cycle.
      if (abort) begin
        busy <= 1'b0;
        done <= 1'b0;
      end else if (start) begin
        busy <= 1'b1;
        done <= 1'b0;
      end else if (state == ST_DONE) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_oscope_capture_ctrl.sv
// Directed bench for oscope_capture_ctrl with N = 16, SAMPLE_W = 12.
// Builds with or without OSCOPE_AUTO_TRIG_EN.
module tb_oscope_capture_ctrl;

  localparam int SW = 12;
  localparam int DL = 4;
  localparam int TW = 24;

  logic          clk = 1'b0;
  logic          ARESET;
  logic          arm, abort;
  logic [SW-1:0] cfg_level;
  logic          cfg_rising;
  logic [DL-1:0] cfg_pretrig;
  logic [TW-1:0] cfg_timeout;
  logic          smp_valid;
  logic [SW-1:0] smp_data;
  logic          buf_we;
  logic [DL-1:0] buf_addr;
  logic [SW-1:0] buf_wdata;
  logic          busy, done;
  logic [DL-1:0] trig_addr;
  logic          forced;

  int total = 0;
  int bad   = 0;
  int base;

  int            wr_count = 0;
  logic [SW-1:0] mem [16];
  logic [DL-1:0] wr_addr_log [256];

  always #5 clk = ~clk;

  oscope_capture_ctrl #(.SAMPLE_W(SW), .DEPTH_LOG2(DL), .TIMEOUT_W(TW)) dut (
    .ACLK        (clk),
    .ARESET      (ARESET),
    .arm         (arm),
    .abort       (abort),
    .cfg_level   (cfg_level),
    .cfg_rising  (cfg_rising),
    .cfg_pretrig (cfg_pretrig),
    .cfg_timeout (cfg_timeout),
    .smp_valid   (smp_valid),
    .smp_data    (smp_data),
    .buf_we      (buf_we),
    .buf_addr    (buf_addr),
    .buf_wdata   (buf_wdata),
    .busy        (busy),
    .done        (done),
    .trig_addr   (trig_addr),
    .forced      (forced)
  );

  // Buffer image and write log, sampled mid-cycle.
  always @(negedge clk) begin
    if (buf_we) begin
      mem[buf_addr]               <= buf_wdata;
      wr_addr_log[wr_count[7:0]]  <= buf_addr;
      wr_count                    <= wr_count + 1;
    end
  end

  task automatic applyStimulus(input logic v, input logic [SW-1:0] d,
                               input logic a, input logic ab);
    smp_valid = v;
    smp_data  = d;
    arm       = a;
    abort     = ab;
    @(posedge clk);
    #1;
    smp_valid = 1'b0;
    arm       = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    ARESET = 1'b1; arm = 1'b0; abort = 1'b0; smp_valid = 1'b0; smp_data = '0;
    cfg_level = '0; cfg_rising = 1'b0; cfg_pretrig = '0; cfg_timeout = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_we", 32'(buf_we), 0);
    checkOutput("rst_addr", 32'(buf_addr), 0);
    checkOutput("rst_trig_addr", 32'(trig_addr), 0);
    checkOutput("rst_forced", 32'(forced), 0);
    ARESET = 1'b0;

    $display("[TB] rising trigger, pretrig 4");
    cfg_level = 12'h100; cfg_rising = 1'b1; cfg_pretrig = 4'd4;
    base = wr_count;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t1_busy_after_arm", 32'(busy), 1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, SW'(i * 64), 1'b0, 1'b0);
    checkOutput("t1_last_we", 32'(buf_we), 1);
    checkOutput("t1_done_not_early", 32'(done), 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t1_done", 32'(done), 1);
    checkOutput("t1_busy_low", 32'(busy), 0);
    checkOutput("t1_trig_addr", 32'(trig_addr), 4);
    checkOutput("t1_forced", 32'(forced), 0);
    checkOutput("t1_writes", 32'(wr_count - base), 16);
    for (int a = 0; a < 16; a++) checkOutput("t1_buf", 32'(mem[a]), 32'(a * 64));
    applyStimulus(1'b1, 12'h555, 1'b0, 1'b0);
    applyStimulus(1'b1, 12'h556, 1'b0, 1'b0);
    checkOutput("t1_no_write_in_done", 32'(wr_count - base), 16);
    checkOutput("t1_done_held", 32'(done), 1);

    $display("[TB] pointer wrap, re-arm from DONE");
    base = wr_count;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t2_done_cleared", 32'(done), 0);
    checkOutput("t2_busy", 32'(busy), 1);
    for (int i = 0; i < 32; i++)
      applyStimulus(1'b1, (i < 20) ? SW'(16 + i) : SW'(256 + i), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t2_done", 32'(done), 1);
    checkOutput("t2_trig_addr", 32'(trig_addr), 4);
    checkOutput("t2_writes", 32'(wr_count - base), 32);
    checkOutput("t2_first_addr", 32'(wr_addr_log[base[7:0]]), 0);
    checkOutput("t2_wrap_addr", 32'(wr_addr_log[8'(base + 16)]), 0);
    checkOutput("t2_oldest", 32'(mem[0]), 32'h020);
    checkOutput("t2_trig_sample", 32'(mem[4]), 32'h114);
    checkOutput("t2_newest", 32'(mem[15]), 32'h11F);

    $display("[TB] falling trigger, pretrig 0");
    cfg_rising = 1'b0; cfg_pretrig = 4'd0;
    base = wr_count;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t3_busy", 32'(busy), 1);
    applyStimulus(1'b1, 12'h050, 1'b0, 1'b0);
    applyStimulus(1'b1, 12'h200, 1'b0, 1'b0);
    applyStimulus(1'b1, 12'h0FF, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 12'h0F0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t3_done", 32'(done), 1);
    checkOutput("t3_trig_addr", 32'(trig_addr), 2);
    checkOutput("t3_writes", 32'(wr_count - base), 18);
    checkOutput("t3_trig_sample", 32'(mem[2]), 32'h0FF);

    $display("[TB] abort in POST, arm with abort");
    cfg_rising = 1'b1; cfg_pretrig = 4'd4;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, SW'(i * 64), 1'b0, 1'b0);
    checkOutput("t4_busy_in_post", 32'(busy), 1);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("t4_abort_busy", 32'(busy), 0);
    checkOutput("t4_abort_done", 32'(done), 0);
    checkOutput("t4_abort_we", 32'(buf_we), 0);
    base = wr_count;
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 12'h300, 1'b0, 1'b0);
    checkOutput("t4_no_writes", 32'(wr_count - base), 0);
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    checkOutput("t4_arm_abort_busy", 32'(busy), 0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 12'h300, 1'b0, 1'b0);
    checkOutput("t4_arm_abort_writes", 32'(wr_count - base), 0);

    $display("[TB] arm ignored while ARMED");
    base = wr_count;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, SW'(i * 64), 1'b0, 1'b0);
    cfg_pretrig = 4'd8;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    checkOutput("t5_busy", 32'(busy), 1);
    for (int i = 4; i < 12; i++) applyStimulus(1'b1, SW'(i * 64), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t5_not_done_yet", 32'(done), 0);
    for (int i = 12; i < 16; i++) applyStimulus(1'b1, SW'(i * 64), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t5_done", 32'(done), 1);
    checkOutput("t5_trig_addr", 32'(trig_addr), 4);
    checkOutput("t5_writes", 32'(wr_count - base), 16);
    cfg_pretrig = 4'd0;

    $display("[TB] auto-trigger timeout 50, flat input");
    cfg_level = 12'h800; cfg_rising = 1'b1; cfg_timeout = 24'd50;
    base = wr_count;
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
`ifdef OSCOPE_AUTO_TRIG_EN
    for (int i = 0; i < 66; i++) applyStimulus(1'b1, 12'h100, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    checkOutput("t6_done", 32'(done), 1);
    checkOutput("t6_forced", 32'(forced), 1);
    checkOutput("t6_trig_addr", 32'(trig_addr), 2);
    checkOutput("t6_writes", 32'(wr_count - base), 66);
`else
    for (int i = 0; i < 80; i++) applyStimulus(1'b1, 12'h100, 1'b0, 1'b0);
    checkOutput("t6_busy_stays", 32'(busy), 1);
    checkOutput("t6_no_done", 32'(done), 0);
    checkOutput("t6_not_forced", 32'(forced), 0);
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    checkOutput("t6_abort_busy", 32'(busy), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
